// File: rtl/apb_pkg.sv
// Shared APB bus definitions.
// Used by the APB master and slave.
package apb_pkg;

  localparam int APB_ADDR_W = 4;
  localparam int APB_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_regfile.sv
// APB register file: one sync write port,
// one combinational read port, sync reset.
module apb_regfile
  import apb_pkg::*;
#(
  parameter int ADDR_W   = APB_ADDR_W,
  parameter int DATA_W   = APB_DATA_W,
  parameter int NUM_REGS = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);

  logic [DATA_W-1:0] mem [NUM_REGS];

  // Storage: clear on reset, write mapped addresses only.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem[i] <= '0;
    end else if (we && (waddr <= LAST)) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port: unmapped addresses return zero.
  always_comb begin
    rdata = '0;
    if (raddr <= LAST)
      rdata = mem[raddr];
  end

endmodule

// File: rtl/apb_slave.sv
// APB completer with programmable wait
// states in front of a local register file.
module apb_slave
  import apb_pkg::*;
#(
  parameter int ADDR_W      = APB_ADDR_W,
  parameter int DATA_W      = APB_DATA_W,
  parameter int NUM_REGS    = 12,
  parameter int WAIT_STATES = 2
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              pselx,
  input  logic              penable,
  input  logic [ADDR_W-1:0] paddr,
  input  logic              pwrite,
  input  logic [DATA_W-1:0] pwdata,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr
);

  localparam int CW =
    (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam bit NOWAIT = (WAIT_STATES == 0);
  localparam logic [ADDR_W-1:0] LAST =
    ADDR_W'(NUM_REGS - 1);

  apb_state_e        state_q, state_d;
  logic [CW-1:0]     wcnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              pready_q;
  logic              pslverr_q;
  logic [DATA_W-1:0] prdata_q;

  logic              setup;
  logic              ld, dec, fire, done;
  logic [ADDR_W-1:0] raddr;
  logic [DATA_W-1:0] rdata;
  logic              mapped;
  logic              we;

  assign setup = pselx & ~penable;

  // Next state and per-edge control strobes.
  always_comb begin
    state_d = state_q;
    ld      = 1'b0;
    dec     = 1'b0;
    fire    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (setup) begin
          state_d = ACCESS;
          ld      = 1'b1;
        end
      end
      ACCESS: begin
        if (!pselx) begin
          state_d = IDLE;
        end else if (penable) begin
          if (pready_q) begin
            done    = 1'b1;
            state_d = DONE;
          end else if (wcnt_q != '0) begin
            dec  = 1'b1;
            fire = (wcnt_q == CW'(1));
          end
        end
      end
      DONE: begin
        if (setup) begin
          state_d = ACCESS;
          ld      = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (ld && NOWAIT)
      fire = 1'b1;
  end

  // With no wait states the response forms on
  // the setup edge, before the address is latched.
  assign raddr  = ld ? paddr : addr_q;
  assign mapped = (raddr <= LAST);
  assign we     = done & wr_q & (addr_q <= LAST);

  // State, setup latches, wait counter, response.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q   <= IDLE;
      wcnt_q    <= '0;
      addr_q    <= '0;
      wr_q      <= 1'b0;
      wdata_q   <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      prdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ld) begin
        addr_q  <= paddr;
        wr_q    <= pwrite;
        wdata_q <= pwdata;
        wcnt_q  <= CW'(WAIT_STATES);
      end else if (dec) begin
        wcnt_q <= wcnt_q - CW'(1);
      end
      if (fire) begin
        pready_q  <= 1'b1;
        pslverr_q <= ~mapped;
        prdata_q  <= mapped ? rdata : '0;
      end else if (done || state_d == IDLE) begin
        pready_q  <= 1'b0;
        pslverr_q <= 1'b0;
      end
    end
  end

  apb_regfile #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .NUM_REGS(NUM_REGS)
  ) u_regs (
    .clk  (pclk),
    .rst  (preset),
    .we   (we),
    .waddr(addr_q),
    .wdata(wdata_q),
    .raddr(raddr),
    .rdata(rdata)
  );

  assign pready  = pready_q;
  assign prdata  = prdata_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_slave.sv
// Directed bench for apb_slave with two
// builds: 2 wait states and 0 wait states.
module tb_apb_slave;
  import apb_pkg::*;

  logic        pclk = 1'b0;
  logic        preset;
  logic        pselx;
  logic        penable;
  logic [3:0]  paddr;
  logic        pwrite;
  logic [15:0] pwdata;
  logic        rdy, err;
  logic [15:0] rdat;
  logic        rdy0, err0;
  logic [15:0] rdat0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 pclk = ~pclk;

  apb_slave #(.WAIT_STATES(2)) dut (
    .pclk   (pclk),
    .preset (preset),
    .pselx  (pselx),
    .penable(penable),
    .paddr  (paddr),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pready (rdy),
    .prdata (rdat),
    .pslverr(err)
  );

  apb_slave #(.WAIT_STATES(0)) dut0 (
    .pclk   (pclk),
    .preset (preset),
    .pselx  (pselx),
    .penable(penable),
    .paddr  (paddr),
    .pwrite (pwrite),
    .pwdata (pwdata),
    .pready (rdy0),
    .prdata (rdat0),
    .pslverr(err0)
  );

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  // One transfer, starting at a negedge.
  task automatic xfer(input bit z,
                      input logic [3:0] a,
                      input bit w,
                      input logic [15:0] d,
                      input bit b2b,
                      output logic [15:0] rd,
                      output logic e,
                      output int lat);
    pselx   = 1'b1;
    penable = 1'b0;
    paddr   = a;
    pwrite  = w;
    pwdata  = d;
    @(negedge pclk);
    penable = 1'b1;
    lat = 1;
    while (!(z ? rdy0 : rdy) && lat < 16) begin
      @(negedge pclk);
      lat++;
    end
    rd = z ? rdat0 : rdat;
    e  = z ? err0 : err;
    @(negedge pclk);
    if (!b2b) begin
      pselx   = 1'b0;
      penable = 1'b0;
      @(negedge pclk);
    end
  endtask

  logic [15:0] rd;
  logic        e;
  int          lat;

  initial begin
    preset  = 1'b1;
    pselx   = 1'b0;
    penable = 1'b0;
    paddr   = '0;
    pwrite  = 1'b0;
    pwdata  = '0;
    repeat (2) @(negedge pclk);
    check("rst_pready", 32'(rdy), 32'h0);
    check("rst_prdata", 32'(rdat), 32'h0);
    check("rst_pslverr", 32'(err), 32'h0);
    preset = 1'b0;
    @(negedge pclk);

    xfer(0, 4'h3, 0, 16'h0, 0, rd, e, lat);
    check("rst_rd3", 32'(rd), 32'h0);

    xfer(0, 4'h5, 1, 16'hABAB, 0, rd, e, lat);
    check("wr5_lat", 32'(lat), 32'd3);
    check("wr5_err", 32'(e), 32'h0);
    check("wr5_rdy_drop", 32'(rdy), 32'h0);
    xfer(0, 4'h5, 0, 16'h0, 0, rd, e, lat);
    check("rd5_data", 32'(rd), 32'hABAB);
    check("rd5_err", 32'(e), 32'h0);

    xfer(0, 4'h4, 1, 16'h0066, 1, rd, e, lat);
    xfer(0, 4'h4, 0, 16'h0, 0, rd, e, lat);
    check("b2b_rd4", 32'(rd), 32'h0066);
    check("b2b_lat", 32'(lat), 32'd3);

    xfer(0, 4'hE, 1, 16'h1234, 0, rd, e, lat);
    check("unm_wr_err", 32'(e), 32'h1);
    xfer(0, 4'hE, 0, 16'h0, 0, rd, e, lat);
    check("unm_rd_data", 32'(rd), 32'h0);
    check("unm_rd_err", 32'(e), 32'h1);
    xfer(0, 4'h5, 0, 16'h0, 0, rd, e, lat);
    check("unm_keep5", 32'(rd), 32'hABAB);
    check("unm_err_clr", 32'(e), 32'h0);
    xfer(0, 4'h2, 0, 16'h0, 0, rd, e, lat);
    check("unm_keep2", 32'(rd), 32'h0);

    pselx   = 1'b1;
    penable = 1'b0;
    paddr   = 4'h2;
    pwrite  = 1'b1;
    pwdata  = 16'hBEEF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    pselx   = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    check("abort_rdy", 32'(rdy), 32'h0);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    xfer(0, 4'h2, 0, 16'h0, 0, rd, e, lat);
    check("abort_rd2", 32'(rd), 32'h0);
    xfer(0, 4'h5, 0, 16'h0, 0, rd, e, lat);
    check("abort_keep5", 32'(rd), 32'hABAB);

    pselx   = 1'b1;
    penable = 1'b0;
    paddr   = 4'h2;
    pwrite  = 1'b1;
    pwdata  = 16'hBEEF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    preset = 1'b1;
    @(negedge pclk);
    preset  = 1'b0;
    pselx   = 1'b0;
    penable = 1'b0;
    check("prst_state", 32'(dut.state_q), 32'(IDLE));
    check("prst_rdy", 32'(rdy), 32'h0);
    @(negedge pclk);
    xfer(0, 4'h2, 0, 16'h0, 0, rd, e, lat);
    check("prst_rd2", 32'(rd), 32'h0);

    for (int i = 0; i < 4; i++)
      xfer(1, 4'(i), 1, 16'(16'h1111 * (i + 1)),
           1, rd, e, lat);
    for (int i = 0; i < 4; i++) begin
      xfer(1, 4'(i), 0, 16'h0, 1, rd, e, lat);
      check($sformatf("ws0_rd%0d", i), 32'(rd),
            32'(16'h1111 * (i + 1)));
      check($sformatf("ws0_lat%0d", i), 32'(lat),
            32'd1);
    end
    pselx   = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    check("ws0_rdy_drop", 32'(rdy0), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
